lif_param_loader: RTL and testbench

//  Byte-stream configuration loader directly upstream of the LIF neuron core.

---
 rtl/lif_param_loader.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_lif_param_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_param_loader.sv
// ============================================================================
// Module : lif_param_loader
//
// Purpose
//   Byte-stream configuration loader that sits directly in front of the LIF
//   neuron core. Framed configuration bytes arrive over a valid/ready
//   interface and are collected into shadow registers. The committed
//   parameter set (weight_a, weight_b, leak_config, threshold_min,
//   threshold_max) is updated atomically, and only once the whole frame has
//   been received and validated. params_ready goes high at the first
//   successful commit and stays high until reset.
//
//   Frame layout (one byte per transfer):
//     0: SYNC_BYTE
//     1: {weight_a[2:0], weight_b[2:0], leak_config[1:0]}
//     2: threshold_min
//     3: threshold_max
//     4: checksum = byte1 ^ byte2 ^ byte3   (only with LIF_CFG_CHECKSUM_EN)
//
// Configuration macro
//   LIF_CFG_CHECKSUM_EN : when defined, a checksum byte follows
//                         threshold_max. A mismatch rejects the frame with
//                         err_code = 2. When undefined, there is no checksum
//                         state and err_code = 2 is never produced.
//
// Ports
//   clk            in   1  system clock
//   reset          in   1  asynchronous, active-high reset
//   cfg_data       in   8  configuration byte
//   cfg_valid      in   1  cfg_data is valid
//   cfg_ready      out  1  loader can accept a byte (low only during COMMIT)
//   weight_a       out  3  committed weight A
//   weight_b       out  3  committed weight B
//   leak_config    out  2  committed leak select
//   threshold_min  out  8  committed threshold floor
//   threshold_max  out  8  committed threshold ceiling
//   params_ready   out  1  high after the first successful commit
//   cfg_err        out  1  one-cycle pulse on a rejected or aborted frame
//   err_code       out  2  sticky last error: 0 none, 1 min>max,
//                          2 checksum, 3 timeout
// ============================================================================
module lif_param_loader #(
    parameter logic [2:0] DEF_WEIGHT_A   = 3'd2,
    parameter logic [2:0] DEF_WEIGHT_B   = 3'd2,
    parameter logic [1:0] DEF_LEAK       = 2'd0,
    parameter logic [7:0] DEF_THR_MIN    = 8'd32,
    parameter logic [7:0] DEF_THR_MAX    = 8'd128,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic [2:0] weight_a,
    output logic [2:0] weight_b,
    output logic [1:0] leak_config,
    output logic [7:0] threshold_min,
    output logic [7:0] threshold_max,
    output logic       params_ready,
    output logic       cfg_err,
    output logic [1:0] err_code
);

    // The idle counter is at least 5 bits wide. It widens automatically if a
    // larger TIMEOUT_CYCLES is chosen.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_BYTE = 3'd1,
        S_TMIN   = 3'd2,
        S_TMAX   = 3'd3,
        S_COMMIT = 3'd4
`ifdef LIF_CFG_CHECKSUM_EN
        , S_CSUM = 3'd5
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idleCnt_q, idleCnt_d;

    // Shadow copy of the frame payload. It is only visible on the outputs
    // after a successful commit.
    logic [7:0]       shWeights_q, shWeights_d;
    logic [7:0]       shThrMin_q, shThrMin_d;
    logic [7:0]       shThrMax_q, shThrMax_d;
`ifdef LIF_CFG_CHECKSUM_EN
    logic             csumOk_q, csumOk_d;
`endif

    // Committed parameter set and status
    logic [2:0]       weightA_q, weightA_d;
    logic [2:0]       weightB_q, weightB_d;
    logic [1:0]       leak_q, leak_d;
    logic [7:0]       thrMin_q, thrMin_d;
    logic [7:0]       thrMax_q, thrMax_d;
    logic             paramsReady_q, paramsReady_d;
    logic             cfgErr_q, cfgErr_d;
    logic [1:0]       errCode_q, errCode_d;

    logic             xfer;
    logic             inFrame;
    logic             expire;

    // The loader refuses data only in the single COMMIT cycle.
    assign cfg_ready = (state_q != S_COMMIT);
    assign xfer      = cfg_valid & cfg_ready;

    // inFrame covers the states that wait for a payload byte. Only these
    // states advance the inactivity timeout.
    always_comb begin
        inFrame = 1'b0;
        case (state_q)
            S_W_BYTE, S_TMIN, S_TMAX: inFrame = 1'b1;
`ifdef LIF_CFG_CHECKSUM_EN
            S_CSUM:                   inFrame = 1'b1;
`endif
            default:                  inFrame = 1'b0;
        endcase
    end

    // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle cycle. If a
    // transfer happens in that same cycle, the transfer takes priority.
    assign expire = inFrame & ~xfer & (idleCnt_q == CNT_LAST);

    // Next-state logic: frame sequencing, shadow capture, the commit
    // decision, and timeout handling.
    always_comb begin
        state_d       = state_q;
        idleCnt_d     = idleCnt_q;
        shWeights_d   = shWeights_q;
        shThrMin_d    = shThrMin_q;
        shThrMax_d    = shThrMax_q;
`ifdef LIF_CFG_CHECKSUM_EN
        csumOk_d      = csumOk_q;
`endif
        weightA_d     = weightA_q;
        weightB_d     = weightB_q;
        leak_d        = leak_q;
        thrMin_d      = thrMin_q;
        thrMax_d      = thrMax_q;
        paramsReady_d = paramsReady_q;
        cfgErr_d      = 1'b0;
        errCode_d     = errCode_q;

        if (!inFrame || xfer) begin
            idleCnt_d = '0;
        end else begin
            idleCnt_d = idleCnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Any byte other than the sync marker is dropped silently.
                if (xfer && (cfg_data == SYNC_BYTE)) begin
                    state_d = S_W_BYTE;
                end
            end

            S_W_BYTE: begin
                if (xfer) begin
                    shWeights_d = cfg_data;
                    state_d     = S_TMIN;
                end
            end

            S_TMIN: begin
                if (xfer) begin
                    shThrMin_d = cfg_data;
                    state_d    = S_TMAX;
                end
            end

            S_TMAX: begin
                if (xfer) begin
                    shThrMax_d = cfg_data;
`ifdef LIF_CFG_CHECKSUM_EN
                    state_d    = S_CSUM;
`else
                    state_d    = S_COMMIT;
`endif
                end
            end

`ifdef LIF_CFG_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    csumOk_d = (cfg_data == (shWeights_q ^ shThrMin_q ^ shThrMax_q));
                    state_d  = S_COMMIT;
                end
            end
`endif

            S_COMMIT: begin
                state_d = S_IDLE;
                // A range violation is reported ahead of a checksum error.
                if (shThrMin_q > shThrMax_q) begin
                    cfgErr_d  = 1'b1;
                    errCode_d = ERR_RANGE;
                end
`ifdef LIF_CFG_CHECKSUM_EN
                else if (!csumOk_q) begin
                    cfgErr_d  = 1'b1;
                    errCode_d = ERR_CHECKSUM;
                end
`endif
                else begin
                    weightA_d     = shWeights_q[7:5];
                    weightB_d     = shWeights_q[4:2];
                    leak_d        = shWeights_q[1:0];
                    thrMin_d      = shThrMin_q;
                    thrMax_d      = shThrMax_q;
                    paramsReady_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // On a timeout, drop the partial frame. The next frame overwrites
        // every shadow byte before it can reach COMMIT, so the stale shadow
        // contents are never used.
        if (expire) begin
            state_d   = S_IDLE;
            idleCnt_d = '0;
            cfgErr_d  = 1'b1;
            errCode_d = ERR_TIMEOUT;
        end
    end

    // State and data registers. Reset restores the default parameter set and
    // abandons any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idleCnt_q     <= '0;
            shWeights_q   <= '0;
            shThrMin_q    <= '0;
            shThrMax_q    <= '0;
`ifdef LIF_CFG_CHECKSUM_EN
            csumOk_q      <= 1'b0;
`endif
            weightA_q     <= DEF_WEIGHT_A;
            weightB_q     <= DEF_WEIGHT_B;
            leak_q        <= DEF_LEAK;
            thrMin_q      <= DEF_THR_MIN;
            thrMax_q      <= DEF_THR_MAX;
            paramsReady_q <= 1'b0;
            cfgErr_q      <= 1'b0;
            errCode_q     <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            idleCnt_q     <= idleCnt_d;
            shWeights_q   <= shWeights_d;
            shThrMin_q    <= shThrMin_d;
            shThrMax_q    <= shThrMax_d;
`ifdef LIF_CFG_CHECKSUM_EN
            csumOk_q      <= csumOk_d;
`endif
            weightA_q     <= weightA_d;
            weightB_q     <= weightB_d;
            leak_q        <= leak_d;
            thrMin_q      <= thrMin_d;
            thrMax_q      <= thrMax_d;
            paramsReady_q <= paramsReady_d;
            cfgErr_q      <= cfgErr_d;
            errCode_q     <= errCode_d;
        end
    end

    assign weight_a      = weightA_q;
    assign weight_b      = weightB_q;
    assign leak_config   = leak_q;
    assign threshold_min = thrMin_q;
    assign threshold_max = thrMax_q;
    assign params_ready  = paramsReady_q;
    assign cfg_err       = cfgErr_q;
    assign err_code      = errCode_q;

endmodule

// File: tb/tb_lif_param_loader.sv
// ============================================================================
// Testbench : tb_lif_param_loader
//
// Drives randomized and directed configuration frames into lif_param_loader.
// A reference model of the committed parameter set predicts the outcome of
// each frame, and the predictions are queued. A monitor process watches for
// the cycle after a COMMIT, and for standalone cfg_err pulses. At each such
// event it pops the next prediction and compares it with the DUT outputs.
// ============================================================================
module tb_lif_param_loader;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 16;
`ifdef LIF_CFG_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] weight_a;
    logic [2:0] weight_b;
    logic [1:0] leak_config;
    logic [7:0] threshold_min;
    logic [7:0] threshold_max;
    logic       params_ready;
    logic       cfg_err;
    logic [1:0] err_code;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [2:0] wa;
        logic [2:0] wb;
        logic [1:0] leak;
        logic [7:0] tmin;
        logic [7:0] tmax;
        logic       pr;
        logic       err;
        logic [1:0] code;
    } exp_t;

    exp_t expQ[$];

    // Reference model of the committed state
    logic [2:0] mWa, mWb;
    logic [1:0] mLeak;
    logic [7:0] mMin, mMax;
    logic       mPr;
    logic [1:0] mCode;

    lif_param_loader dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .weight_a      (weight_a),
        .weight_b      (weight_b),
        .leak_config   (leak_config),
        .threshold_min (threshold_min),
        .threshold_max (threshold_max),
        .params_ready  (params_ready),
        .cfg_err       (cfg_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mWa   = 3'd2;
        mWb   = 3'd2;
        mLeak = 2'd0;
        mMin  = 8'd32;
        mMax  = 8'd128;
        mPr   = 1'b0;
        mCode = 2'd0;
    endtask

    // Predict the outcome of a complete frame.
    task automatic modelFrame(input logic [7:0] w, input logic [7:0] mn,
                              input logic [7:0] mx, input logic [7:0] cs);
        exp_t e;
        int   code;
        code = 0;
        if (mn > mx) code = 1;
        else if (CSUM_EN && (cs != (w ^ mn ^ mx))) code = 2;
        if (code == 0) begin
            mWa   = w[7:5];
            mWb   = w[4:2];
            mLeak = w[1:0];
            mMin  = mn;
            mMax  = mx;
            mPr   = 1'b1;
        end else begin
            mCode = 2'(code);
        end
        e.wa = mWa; e.wb = mWb; e.leak = mLeak; e.tmin = mMin; e.tmax = mMax;
        e.pr = mPr; e.err = (code != 0); e.code = mCode;
        expQ.push_back(e);
    endtask

    task automatic modelTimeout();
        exp_t e;
        mCode = 2'd3;
        e.wa = mWa; e.wb = mWb; e.leak = mLeak; e.tmin = mMin; e.tmax = mMax;
        e.pr = mPr; e.err = 1'b1; e.code = mCode;
        expQ.push_back(e);
    endtask

    // Present one byte, then wait for it to be accepted. Waiting while
    // cfg_ready is low is bounded.
    task automatic sendByte(input logic [7:0] b);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        cfg_data  = b;
        cfg_valid = 1'b1;
        while (!cfg_ready && waitCnt < 8) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cfg_ready) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL ready_wait: cfg_ready stuck at %0d, expected 1", cfg_ready);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cfg_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    function automatic int pickGap(input int gap);
        return (gap < 0) ? int'($urandom_range(3, 0)) : gap;
    endfunction

    // Send one complete frame and queue its predicted outcome. A negative
    // gap selects random spacing between bytes.
    task automatic applyStimulus(input logic [7:0] w, input logic [7:0] mn,
                                 input logic [7:0] mx, input logic badCs, input int gap);
        logic [7:0] cs;
        cs = w ^ mn ^ mx;
        if (badCs) cs = ~cs;
        modelFrame(w, mn, mx, cs);
        sendByte(SYNC);
        idle(pickGap(gap));
        sendByte(w);
        idle(pickGap(gap));
        sendByte(mn);
        idle(pickGap(gap));
        sendByte(mx);
        if (CSUM_EN) begin
            idle(pickGap(gap));
            sendByte(cs);
        end
    endtask

    task automatic drainQueue();
        int w;
        w = 0;
        while (expQ.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (expQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d outcomes still pending, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic checkDefaults();
        checkOutput("def_weight_a", int'(weight_a), 2);
        checkOutput("def_weight_b", int'(weight_b), 2);
        checkOutput("def_leak", int'(leak_config), 0);
        checkOutput("def_thr_min", int'(threshold_min), 32);
        checkOutput("def_thr_max", int'(threshold_max), 128);
        checkOutput("def_params_ready", int'(params_ready), 0);
        checkOutput("def_cfg_ready", int'(cfg_ready), 1);
        checkOutput("def_cfg_err", int'(cfg_err), 0);
        checkOutput("def_err_code", int'(err_code), 0);
    endtask

    // Monitor. An outcome is due in the cycle after COMMIT (seen as
    // cfg_ready low at the previous sample), or whenever cfg_err pulses
    // outside that cycle (timeout).
    initial begin : monitor
        logic prevLow;
        exp_t e;
        prevLow = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevLow = 1'b0;
            end else begin
                if (prevLow || cfg_err) begin
                    if (expQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpected_event: cfg_err=%0d err_code=%0d with no outcome pending",
                                 cfg_err, err_code);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("weight_a", int'(weight_a), int'(e.wa));
                        checkOutput("weight_b", int'(weight_b), int'(e.wb));
                        checkOutput("leak_config", int'(leak_config), int'(e.leak));
                        checkOutput("threshold_min", int'(threshold_min), int'(e.tmin));
                        checkOutput("threshold_max", int'(threshold_max), int'(e.tmax));
                        checkOutput("params_ready", int'(params_ready), int'(e.pr));
                        checkOutput("cfg_err", int'(cfg_err), int'(e.err));
                        checkOutput("err_code", int'(err_code), int'(e.code));
                    end
                end
                prevLow = !cfg_ready;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] w, mn, mx, junk;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        reset     = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state check");
        checkDefaults();

        $display("[TB] directed valid frame");
        applyStimulus(8'b111_011_10, 8'd10, 8'd200, 1'b0, 0);
        drainQueue();

        $display("[TB] min greater than max");
        applyStimulus(8'h5B, 8'd150, 8'd100, 1'b0, 0);
        drainQueue();

        $display("[TB] timeout after sync");
        sendByte(SYNC);
        modelTimeout();
        idle(TIMEOUT);
        drainQueue();
        sendByte(8'h10);
        applyStimulus(8'b010_101_01, 8'd40, 8'd90, 1'b0, -1);
        drainQueue();

        $display("[TB] equal thresholds and mid-frame sync value");
        applyStimulus(SYNC, 8'd77, 8'd77, 1'b0, -1);
        drainQueue();

        $display("[TB] longest gap that does not time out");
        applyStimulus(8'b001_110_11, 8'd0, 8'd255, 1'b0, TIMEOUT - 1);
        drainQueue();

        if (CSUM_EN) begin
            $display("[TB] bad checksum");
            applyStimulus(8'b100_001_01, 8'd20, 8'd60, 1'b1, 0);
            drainQueue();
        end

        $display("[TB] randomized frames");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                junk = 8'($urandom);
                if (junk == SYNC) junk = 8'h5A;
                sendByte(junk);
            end
            w  = 8'($urandom);
            mn = 8'($urandom);
            mx = 8'($urandom);
            applyStimulus(w, mn, mx, ($urandom_range(3, 0) == 0), -1);
        end
        drainQueue();

        $display("[TB] reset in the middle of a frame");
        sendByte(SYNC);
        sendByte(8'hFF);
        sendByte(8'd5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        modelReset();
        checkDefaults();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(8'b110_010_01, 8'd12, 8'd34, 1'b0, -1);
        drainQueue();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
